instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the opcode decoder/controller.
- Holds the fetch PC and issues requests to the instruction memory. Memory latency is variable.
- Buffers returned instructions in a small in-order FIFO.
- Presents {pc, instr, opcode} to decode over a valid/ready handshake. Supports a branch/jump redirect that flushes all in-flight work.

Parameters:
- XLEN, 32, address/instruction width
- RESET_PC, 32'h0000_0000, fetch PC after reset
- FIFO_DEPTH, 2, output buffer entries; also the cap on (outstanding requests + buffered entries)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req_o  output  1  fetch request valid
- imem_addr_o  output  XLEN  fetch address, word aligned
- imem_gnt_i  input  1  request accepted this cycle
- imem_rvalid_i  input  1  response valid; responses return in request order
- imem_rdata_i  input  XLEN  returned instruction word
- redirect_i  input  1  branch/jump taken; flush and restart
- redirect_pc_i  input  XLEN  new fetch PC; bits [1:0] forced to 0
- if_valid_o  output  1  instruction available to decode
- if_ready_i  input  1  decode accepts instruction
- if_instr_o  output  XLEN  instruction word
- if_pc_o  output  XLEN  PC of if_instr_o
- if_opcode_o  output  7  if_instr_o[6:0], fed to the controller

Behaviour:
- Reset (async, active-high): fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO empty.
  - Outputs during reset: imem_req_o=0, if_valid_o=0, imem_addr_o=RESET_PC, if_instr_o/if_pc_o=0.
  - Reset mid-operation discards everything.
  - Responses arriving while outstanding==0 are ignored.
- Issue rule:
  - imem_req_o=1 when !redirect_i and (outstanding + fifo_count) < FIFO_DEPTH. Both terms are registered values; a pop this cycle frees a credit next cycle.
  - imem_addr_o=fetch_pc.
  - req & gnt: fetch_pc += 4, outstanding += 1.
  - Without gnt, req and addr are held stable.
  - Request withdrawal is permitted only on redirect.
- Response:
  - rvalid: outstanding -= 1.
  - If drop_cnt>0: discard the response, drop_cnt -= 1.
  - Otherwise push {resp_pc, rdata} into the FIFO and set resp_pc += 4.
  - A simultaneous gnt and rvalid leave outstanding unchanged.
- Output:
  - if_valid_o = FIFO non-empty & !redirect_i.
  - if_instr_o, if_pc_o and if_opcode_o come from the FIFO head.
  - Pop on if_valid_o & if_ready_i.
  - Minimum response-to-output latency is 1 cycle; there is no combinational bypass.
  - Head fields are held stable while valid & !ready.
- Redirect (redirect_i=1, takes priority over all else):
  - fetch_pc <= redirect_pc; resp_pc <= redirect_pc.
  - FIFO cleared; no push, no pop.
  - No request issued this cycle.
  - drop_cnt <= outstanding - rvalid. A response arriving in the redirect cycle is discarded.
  - outstanding is updated normally.
  - A redirect while drop_cnt>0 recomputes drop_cnt by the same formula.
  - Back-to-back redirects: the last one wins.
- Arithmetic/wrap: PC adds are modulo 2^XLEN; 32'hFFFF_FFFC + 4 = 0.
- Counter widths: outstanding, drop_cnt and fifo_count are each $clog2(FIFO_DEPTH+1) bits. By construction they never exceed FIFO_DEPTH.
- Full/empty:
  - Push into a full FIFO cannot occur because of the credit rule; assert on it in simulation.
  - Pop on empty is impossible because valid is low.

Decomposition:
- Shared package riscv_pkg:
  - XLEN
  - opcode constants OP_RTYPE=7'b0110011, OP_ITYPE=7'b0010011, OP_LOAD=7'b0000011, OP_STORE=7'b0100011
  - typedef struct packed {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} fetch_entry_t
- Sub-module fetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full. Async reset.

Test Plan:
- Zero-wait memory (gnt=1 every cycle, rvalid 1 cycle after grant with rdata=32'h0000_0033), ready=1 -> first if_valid_o 2 cycles after reset release with pc=0, opcode=7'b0110011; subsequent pcs 4, 8, 12 one per cycle.
- Backpressure: ready=0 for 10 cycles -> exactly 2 requests issued, FIFO holds pcs 0 and 4 stable, imem_req_o=0. After ready=1 -> pcs 0, 4, 8 in order, no gaps or duplicates.
- Redirect to 32'h0000_0100 with 2 outstanding -> both late responses dropped; next if_pc_o=32'h100. Output valid is low in the redirect cycle.
- Redirect in the same cycle as rvalid, plus a redirect to 32'h0000_0203 -> the response is discarded; fetch resumes at 32'h200.
- PC wrap: RESET_PC=32'hFFFF_FFF8 -> if_pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Async reset asserted mid-stream with 2 outstanding -> outputs clear immediately. Later stray rvalid ignored; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch/decode front end.
// fetch_entry_t carries one buffered instruction together with its PC.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched instructions with single-cycle flush.
// Storage is reset to zero so the head fields read as zero out of reset.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t pushData,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t headData,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wrPtr;
    logic [PW-1:0]  rdPtr;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= pushData;
                wrPtr      <= nextPtr(wrPtr);
            end
            if (pop) rdPtr <= nextPtr(rdPtr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign headData = mem[rdPtr];
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    // The upstream credit scheme guarantees a slot for every returning word.
    assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word fetches, buffers in-order responses,
// and hands {pc, instr, opcode} to decode; a redirect flushes all in-flight work.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            if_valid_o,
    input  logic            if_ready_i,
    output logic [XLEN-1:0] if_instr_o,
    output logic [XLEN-1:0] if_pc_o,
    output logic [6:0]      if_opcode_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] respPc;
    logic [XLEN-1:0] redirTarget;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   dropCnt;
    logic [CW-1:0]   fifoCount;
    logic [CW:0]     inFlight;
    logic            fifoEmpty;
    logic            fifoFull;
    logic            issue;
    logic            rspValid;
    logic            dropRsp;
    logic            push;
    logic            pop;
    logic            unusedPcBits;
    fetch_entry_t    pushEntry;
    fetch_entry_t    headEntry;

    // Handshakes: imem transfers on a rising edge with req & gnt, decode on
    // valid & ready. req/addr and the decode head hold steady until taken;
    // only a redirect may withdraw them.
    always_comb begin
        inFlight    = {1'b0, outstanding} + {1'b0, fifoCount};
        imem_req_o  = !reset && !redirect_i && (inFlight < (CW + 1)'(FIFO_DEPTH));
        issue       = imem_req_o && imem_gnt_i;
        rspValid    = imem_rvalid_i && (outstanding != '0);
        dropRsp     = rspValid && (dropCnt != '0);
        push        = rspValid && !dropRsp && !redirect_i;
        if_valid_o  = !fifoEmpty && !redirect_i;
        pop         = if_valid_o && if_ready_i;
        redirTarget = wordAlign(redirect_pc_i);
        pushEntry   = '{pc: respPc, instr: imem_rdata_i};
    end

    assign unusedPcBits = ^redirect_pc_i[1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            outstanding <= '0;
            dropCnt     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(rspValid);
            if (redirect_i) begin
                // Everything still in flight after this edge belongs to the old path.
                fetchPc <= redirTarget;
                respPc  <= redirTarget;
                dropCnt <= outstanding - CW'(rspValid);
            end else begin
                if (issue)   fetchPc <= fetchPc + XLEN'(4);
                if (push)    respPc  <= respPc + XLEN'(4);
                if (dropRsp) dropCnt <= dropCnt - 1'b1;
            end
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pushData (pushEntry),
        .pop      (pop),
        .flush    (redirect_i),
        .headData (headEntry),
        .count    (fifoCount),
        .empty    (fifoEmpty),
        .full     (fifoFull)
    );

    assign imem_addr_o = fetchPc;
    assign if_instr_o  = headEntry.instr;
    assign if_pc_o     = headEntry.pc;
    assign if_opcode_o = headEntry.instr[6:0];

    // A full buffer leaves no credit, so no request can be in flight.
    assert property (@(posedge clk) disable iff (reset) fifoFull |-> (outstanding == '0));

endmodule
